pipe_core_fwd: RTL and testbench
================================

Name: pipe_core_fwd

Overview:
- Parametrised 5-stage integer pipeline core (IF-accept, ID, EX, MEM, WB) with per-stage valid bits, operand forwarding, load-use interlock, flush and stall/backpressure.
- Instructions enter through a valid/ready handshake. Data memory is an external port.
- Successor to the fixed-control datapath: decoding is internal, so no external RegDst/ALUSrc/MemtoReg strobes are needed.

Parameters:
- DWIDTH, 32, datapath and register width.
- IWIDTH, 32, instruction width; fields use MIPS positions.
- AWIDTH_MEM, 32, data-memory byte address width.
- FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = stall on every RAW hazard.
- CNT_WIDTH, 16, retired-instruction counter width.

Ports:
- d_clk  in  1  clock.
- d_rst  in  1  reset, asynchronous, active-low.
- d_i_flush  in  1  synchronous flush of all in-flight instructions.
- d_i_valid  in  1  instruction offered.
- d_i_instr  in  IWIDTH  instruction word.
- d_o_ready  out  1  core accepts d_i_instr this cycle.
- dm_o_addr  out  AWIDTH_MEM  data-memory address, low bits of ALU result.
- dm_o_wdata  out  DWIDTH  store data.
- dm_o_we  out  1  store strobe.
- dm_o_re  out  1  load strobe.
- dm_i_rdata  in  DWIDTH  load data, registered by memory, valid the cycle after dm_o_re.
- d_o_wb_valid  out  1  register write this cycle.
- d_o_wb_addr  out  5  destination register.
- d_o_wb_data  out  DWIDTH  write-back value.
- d_o_stall  out  1  interlock active.
- d_o_retired  out  CNT_WIDTH  count of retired valid instructions.

Behaviour:
- Reset (d_rst low, asynchronous):
  - All stage valids and outputs are 0.
  - Register file r1..r31 = 0; d_o_retired = 0.
  - d_o_ready rises one cycle after reset release.
- Supported instructions:
  - R-type opcode 000000: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed).
  - 001000 ADDI, with sign-extended 16-bit imm.
  - 100011 LW, 101011 SW; address = rs + sext(imm).
  - Any other encoding is a NOP: flows through the pipe and retires, with no write and no memory access.
- Arithmetic: wraps modulo 2^DWIDTH. SLT result is 1 or 0, zero-extended.
- r0: reads as 0. Writes to r0 are suppressed (d_o_wb_valid = 0) and never cause a hazard or a forward.
- Acceptance:
  - An instruction is accepted when d_i_valid && d_o_ready at a rising edge.
  - d_o_ready = !stall && d_rst_synced.
  - Accepted at edge t0 → ID t0..t1, EX t1..t2, MEM t2..t3 (dm strobes driven), WB t3..t4 (d_o_wb_* driven); register written at t4.
  - Instruction-to-write-back latency is 3 cycles after the ID cycle.
- ID register read has write-through: a WB-stage write to the same register is seen in the same cycle.
- FWD_EN = 1:
  - EX operand priority: EX/MEM ALU result (non-load producer), then MEM/WB write-back value, then the ID/EX register value.
  - Load-use: when ID/EX holds an LW whose rt equals the rs of the instruction in ID, or its rt where rt is used (R-type, SW), stall 1 cycle.
  - During the stall: hold IF/ID, d_o_ready = 0, insert a bubble into ID/EX, d_o_stall = 1.
- FWD_EN = 0: stall while any valid ID/EX, EX/MEM or MEM/WB instruction writes a register used by the instruction in ID.
- SW store data is forwarded exactly like the operands.
- Flush: d_i_flush clears IF/ID, ID/EX and EX/MEM valids at the next edge. The MEM/WB instruction still retires. Flush overrides stall and acceptance; an instruction offered that cycle is not accepted.
- Memory strobes:
  - dm_o_we and dm_o_re are asserted only when the EX/MEM stage is valid. They are never both 1.
  - d_o_wb_data = dm_i_rdata for LW, otherwise the ALU result.
- d_o_retired: increments by 1 per valid WB-stage instruction (including NOPs and SW). Wraps at 2^CNT_WIDTH.
- Reset mid-operation: all in-flight instructions are discarded; no strobe is asserted after reset assertion.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 back-to-back, FWD_EN=1 → no stall; WB r3 = 12 exactly 2 cycles after WB r1; d_o_retired = 3.
- SW r3,4(r0); LW r4,4(r0); ADD r5,r4,r4 → dm_o_we with addr 4, data 12; one stall cycle (d_o_ready = 0); WB r5 = 24.
- Same program with FWD_EN=0 → ADD r3 stalls 3 cycles; all results identical.
- ADDI r0,r0,9; ADD r6,r0,r0 → d_o_wb_valid = 0 for r0; r6 = 0; no stall.
- ADDI r1,r0,-1 (imm 16'hFFFF); SLT r2,r1,r0 → r1 = 32'hFFFFFFFF, r2 = 1; SUB r3,r0,r1 → 1.
- Stream of 4 instructions, d_i_flush at the cycle the 4th is offered → only the MEM/WB instruction retires; the 4th is not accepted. Assert d_rst mid-stream → all outputs 0 immediately, then clean restart.

Source files
------------

// File: rtl/pipe_core_fwd.sv
// rtl/pipe_core_fwd.sv - 5-stage integer pipeline core with forwarding, load-use interlock and flush
// IF/ID -> ID/EX -> EX/MEM -> MEM/WB registers; the register file is written at the end of WB.

module pipe_core_fwd #(
  parameter int DWIDTH     = 32,
  parameter int IWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int FWD_EN     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic                  d_i_flush,
  input  logic                  d_i_valid,
  input  logic [IWIDTH-1:0]     d_i_instr,
  output logic                  d_o_ready,
  output logic [AWIDTH_MEM-1:0] dm_o_addr,
  output logic [DWIDTH-1:0]     dm_o_wdata,
  output logic                  dm_o_we,
  output logic                  dm_o_re,
  input  logic [DWIDTH-1:0]     dm_i_rdata,
  output logic                  d_o_wb_valid,
  output logic [4:0]            d_o_wb_addr,
  output logic [DWIDTH-1:0]     d_o_wb_data,
  output logic                  d_o_stall,
  output logic [CNT_WIDTH-1:0]  d_o_retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic              rst_synced;
  logic [DWIDTH-1:0] rf [32];

  logic              ifid_valid;
  logic [IWIDTH-1:0] ifid_instr;

  logic              idex_valid, idex_use_imm, idex_we, idex_load, idex_store;
  alu_op_t           idex_alu;
  logic [4:0]        idex_rs, idex_rt, idex_dest;
  logic [DWIDTH-1:0] idex_rs_val, idex_rt_val, idex_imm;

  logic              exmem_valid, exmem_we, exmem_load, exmem_store;
  logic [4:0]        exmem_dest;
  logic [DWIDTH-1:0] exmem_alu, exmem_sdata;

  logic              memwb_valid, memwb_we, memwb_load;
  logic [4:0]        memwb_dest;
  logic [DWIDTH-1:0] memwb_alu;

  logic [5:0]        id_op, id_funct;
  logic [4:0]        id_rs, id_rt, id_rd, id_dest;
  logic [DWIDTH-1:0] id_imm, id_rs_val, id_rt_val;
  logic              id_use_rs, id_use_rt, id_use_imm, id_wr, id_we, id_load, id_store;
  alu_op_t           id_alu;
  logic              hazard, stall, unused_instr;
  logic [DWIDTH-1:0] ex_a, ex_b, ex_opb, ex_res;

  assign id_op        = ifid_instr[31:26];
  assign id_rs        = ifid_instr[25:21];
  assign id_rt        = ifid_instr[20:16];
  assign id_rd        = ifid_instr[15:11];
  assign id_funct     = ifid_instr[5:0];
  assign id_imm       = {{(DWIDTH-16){ifid_instr[15]}}, ifid_instr[15:0]};
  assign unused_instr = ^ifid_instr;

  always_comb begin
    id_alu = ALU_ADD; id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_imm = 1'b0;
    id_dest = 5'd0; id_wr = 1'b0; id_load = 1'b0; id_store = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        id_use_rs = 1'b1; id_use_rt = 1'b1; id_dest = id_rd; id_wr = 1'b1;
        case (id_funct)
          6'b100000: id_alu = ALU_ADD;
          6'b100010: id_alu = ALU_SUB;
          6'b100100: id_alu = ALU_AND;
          6'b100101: id_alu = ALU_OR;
          6'b101010: id_alu = ALU_SLT;
          default: begin
            id_use_rs = 1'b0; id_use_rt = 1'b0; id_dest = 5'd0; id_wr = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin id_use_rs = 1'b1; id_use_imm = 1'b1; id_dest = id_rt; id_wr = 1'b1; end
      OP_LW:   begin id_use_rs = 1'b1; id_use_imm = 1'b1; id_dest = id_rt; id_wr = 1'b1; id_load = 1'b1; end
      OP_SW:   begin id_use_rs = 1'b1; id_use_rt = 1'b1; id_use_imm = 1'b1; id_store = 1'b1; end
      default: ;
    endcase
  end

  // r0 is never written, so it never participates in hazards or forwarding.
  assign id_we = id_wr && (id_dest != 5'd0);

  assign d_o_wb_valid = memwb_valid && memwb_we;
  assign d_o_wb_addr  = memwb_dest;
  assign d_o_wb_data  = memwb_load ? dm_i_rdata : memwb_alu;

  always_comb begin
    id_rs_val = '0;
    id_rt_val = '0;
    if (id_rs != 5'd0) id_rs_val = (d_o_wb_valid && d_o_wb_addr == id_rs) ? d_o_wb_data : rf[id_rs];
    if (id_rt != 5'd0) id_rt_val = (d_o_wb_valid && d_o_wb_addr == id_rt) ? d_o_wb_data : rf[id_rt];
  end

  function automatic logic reads_reg(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic use_rs, input logic use_rt);
    return (use_rs && dest == rs) || (use_rt && dest == rt);
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = idex_valid && idex_load && idex_we &&
               reads_reg(idex_dest, id_rs, id_rt, id_use_rs, id_use_rt);
    end else begin
      hazard = (idex_valid && idex_we && reads_reg(idex_dest, id_rs, id_rt, id_use_rs, id_use_rt)) ||
               (exmem_valid && exmem_we && reads_reg(exmem_dest, id_rs, id_rt, id_use_rs, id_use_rt)) ||
               (memwb_valid && memwb_we && reads_reg(memwb_dest, id_rs, id_rt, id_use_rs, id_use_rt));
    end
  end

  assign stall     = ifid_valid && hazard && !d_i_flush;
  assign d_o_stall = stall;
  assign d_o_ready = rst_synced && !stall && !d_i_flush;

  always_comb begin
    ex_a = idex_rs_val;
    ex_b = idex_rt_val;
    if (FWD_EN != 0) begin
      if (exmem_valid && exmem_we && !exmem_load && exmem_dest == idex_rs) ex_a = exmem_alu;
      else if (d_o_wb_valid && d_o_wb_addr == idex_rs)                     ex_a = d_o_wb_data;
      if (exmem_valid && exmem_we && !exmem_load && exmem_dest == idex_rt) ex_b = exmem_alu;
      else if (d_o_wb_valid && d_o_wb_addr == idex_rt)                     ex_b = d_o_wb_data;
    end
  end

  assign ex_opb = idex_use_imm ? idex_imm : ex_b;

  always_comb begin
    ex_res = '0;
    case (idex_alu)
      ALU_ADD: ex_res = ex_a + ex_opb;
      ALU_SUB: ex_res = ex_a - ex_opb;
      ALU_AND: ex_res = ex_a & ex_opb;
      ALU_OR:  ex_res = ex_a | ex_opb;
      ALU_SLT: ex_res = {{(DWIDTH-1){1'b0}}, ($signed(ex_a) < $signed(ex_opb))};
      default: ex_res = '0;
    endcase
  end

  assign dm_o_addr  = exmem_alu[AWIDTH_MEM-1:0];
  assign dm_o_wdata = exmem_sdata;
  assign dm_o_we    = exmem_valid && exmem_store;
  assign dm_o_re    = exmem_valid && exmem_load;

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      rst_synced  <= 1'b0;
      ifid_valid  <= 1'b0; ifid_instr  <= '0;
      idex_valid  <= 1'b0; idex_alu    <= ALU_ADD; idex_use_imm <= 1'b0;
      idex_we     <= 1'b0; idex_load   <= 1'b0; idex_store  <= 1'b0;
      idex_rs     <= '0;   idex_rt     <= '0;   idex_dest   <= '0;
      idex_rs_val <= '0;   idex_rt_val <= '0;   idex_imm    <= '0;
      exmem_valid <= 1'b0; exmem_we    <= 1'b0; exmem_load  <= 1'b0; exmem_store <= 1'b0;
      exmem_dest  <= '0;   exmem_alu   <= '0;   exmem_sdata <= '0;
      memwb_valid <= 1'b0; memwb_we    <= 1'b0; memwb_load  <= 1'b0;
      memwb_dest  <= '0;   memwb_alu   <= '0;
      d_o_retired <= '0;
    end else begin
      rst_synced <= 1'b1;
      if (d_i_flush) begin
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= d_i_valid && d_o_ready;
        ifid_instr <= d_i_instr;
      end
      // A stalled ID instruction leaves a bubble behind it in ID/EX.
      idex_valid   <= ifid_valid && !stall && !d_i_flush;
      idex_alu     <= id_alu;     idex_use_imm <= id_use_imm;
      idex_we      <= id_we;      idex_load    <= id_load;   idex_store <= id_store;
      idex_rs      <= id_rs;      idex_rt      <= id_rt;     idex_dest  <= id_dest;
      idex_rs_val  <= id_rs_val;  idex_rt_val  <= id_rt_val; idex_imm   <= id_imm;
      exmem_valid  <= idex_valid && !d_i_flush;
      exmem_we     <= idex_we;    exmem_load   <= idex_load; exmem_store <= idex_store;
      exmem_dest   <= idex_dest;  exmem_alu    <= ex_res;    exmem_sdata <= ex_b;
      memwb_valid  <= exmem_valid;
      memwb_we     <= exmem_we;   memwb_load   <= exmem_load;
      memwb_dest   <= exmem_dest; memwb_alu    <= exmem_alu;
      d_o_retired  <= d_o_retired + CNT_WIDTH'(memwb_valid);
    end
  end

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (d_o_wb_valid) begin
      rf[d_o_wb_addr] <= d_o_wb_data;
    end
  end

endmodule

// File: tb/tb_pipe_core_fwd.sv
// tb/tb_pipe_core_fwd.sv - directed bench for pipe_core_fwd, forwarding and non-forwarding builds
// Instance u_fwd has FWD_EN=1, u_nof has FWD_EN=0; sel chooses which one is driven and observed.

module tb_pipe_core_fwd;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010;

  logic d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  logic        d_rst, drv_valid, drv_flush;
  logic [31:0] drv_instr;
  int          sel;

  logic        rdy_f, we_f, re_f, wbv_f, stl_f;
  logic [31:0] addr_f, wdata_f, rdata_f, wbd_f;
  logic [4:0]  wba_f;
  logic [15:0] ret_f;
  logic        rdy_n, we_n, re_n, wbv_n, stl_n;
  logic [31:0] addr_n, wdata_n, rdata_n, wbd_n;
  logic [4:0]  wba_n;
  logic [15:0] ret_n;

  pipe_core_fwd #(.FWD_EN(1)) u_fwd (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_flush(drv_flush && sel == 0),
    .d_i_valid(drv_valid && sel == 0), .d_i_instr(drv_instr), .d_o_ready(rdy_f),
    .dm_o_addr(addr_f), .dm_o_wdata(wdata_f), .dm_o_we(we_f), .dm_o_re(re_f),
    .dm_i_rdata(rdata_f), .d_o_wb_valid(wbv_f), .d_o_wb_addr(wba_f), .d_o_wb_data(wbd_f),
    .d_o_stall(stl_f), .d_o_retired(ret_f)
  );

  pipe_core_fwd #(.FWD_EN(0)) u_nof (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_flush(drv_flush && sel == 1),
    .d_i_valid(drv_valid && sel == 1), .d_i_instr(drv_instr), .d_o_ready(rdy_n),
    .dm_o_addr(addr_n), .dm_o_wdata(wdata_n), .dm_o_we(we_n), .dm_o_re(re_n),
    .dm_i_rdata(rdata_n), .d_o_wb_valid(wbv_n), .d_o_wb_addr(wba_n), .d_o_wb_data(wbd_n),
    .d_o_stall(stl_n), .d_o_retired(ret_n)
  );

  logic [31:0] mem_f [16];
  logic [31:0] mem_n [16];
  always_ff @(posedge d_clk) begin
    if (we_f) mem_f[addr_f[5:2]] <= wdata_f;
    if (re_f) rdata_f <= mem_f[addr_f[5:2]];
    if (we_n) mem_n[addr_n[5:2]] <= wdata_n;
    if (re_n) rdata_n <= mem_n[addr_n[5:2]];
  end

  logic        c_rdy, c_wbv, c_stl, c_we;
  logic [4:0]  c_wba;
  logic [31:0] c_wbd, c_addr, c_wdata;
  logic [15:0] c_ret;
  assign c_rdy   = sel == 0 ? rdy_f   : rdy_n;
  assign c_wbv   = sel == 0 ? wbv_f   : wbv_n;
  assign c_stl   = sel == 0 ? stl_f   : stl_n;
  assign c_we    = sel == 0 ? we_f    : we_n;
  assign c_wba   = sel == 0 ? wba_f   : wba_n;
  assign c_wbd   = sel == 0 ? wbd_f   : wbd_n;
  assign c_addr  = sel == 0 ? addr_f  : addr_n;
  assign c_wdata = sel == 0 ? wdata_f : wdata_n;
  assign c_ret   = sel == 0 ? ret_f   : ret_n;

  int cyc = 0;
  always @(posedge d_clk) cyc <= cyc + 1;

  logic [4:0]  wb_a [$];
  logic [31:0] wb_d [$];
  logic [31:0] st_a [$];
  logic [31:0] st_d [$];
  int          wb_c [$];
  int          stall_n = 0;

  always @(negedge d_clk) begin
    if (d_rst) begin
      if (c_wbv) begin wb_a.push_back(c_wba); wb_d.push_back(c_wbd); wb_c.push_back(cyc); end
      if (c_we)  begin st_a.push_back(c_addr); st_d.push_back(c_wdata); end
      if (c_stl) stall_n <= stall_n + 1;
    end
  end

  int checks = 0, errors = 0, retry_n = 0;
  int wb0, st0, sn0, rt0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input logic [31:0] ins);
    int tries;
    drv_valid = 1'b1; drv_instr = ins; tries = 0;
    #1;
    while (!c_rdy && tries < 20) begin
      @(negedge d_clk); #1; tries++; retry_n++;
    end
    chk("issue_accept_in_time", 32'(tries < 20), 32'd1);
    @(posedge d_clk);
    @(negedge d_clk);
    drv_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0;
    repeat (n) @(negedge d_clk);
  endtask

  task automatic mark();
    wb0 = wb_a.size(); st0 = st_a.size(); sn0 = stall_n; rt0 = retry_n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; drv_valid = 1'b0; drv_flush = 1'b0; drv_instr = '0; d_rst = 1'b0;
    repeat (3) @(negedge d_clk);
    #1;
    chk("rst_ready", 32'(rdy_f), 0);
    chk("rst_wb_valid", 32'(wbv_f), 0);
    chk("rst_retired", 32'(ret_f), 0);
    chk("rst_stall", 32'(stl_f), 0);
    chk("rst_we", 32'(we_f), 0);
    chk("rst_re", 32'(re_f), 0);
    d_rst = 1'b1;
    #1 chk("ready_before_first_edge", 32'(rdy_f), 0);
    @(negedge d_clk);
    chk("ready_after_release_f", 32'(rdy_f), 1);
    chk("ready_after_release_n", 32'(rdy_n), 1);

    // Back-to-back RAW through forwarding
    mark();
    issue(i_op(OP_ADDI, 1, 0, 16'd5));
    issue(i_op(OP_ADDI, 2, 0, 16'd7));
    issue(r_op(3, 1, 2, F_ADD));
    idle(6);
    chk("p1_wb_count", 32'(wb_a.size() - wb0), 3);
    chk("p1_r1_data", wb_d[wb0], 32'd5);
    chk("p1_r3_addr", 32'(wb_a[wb0+2]), 3);
    chk("p1_r3_data", wb_d[wb0+2], 32'd12);
    chk("p1_r3_latency", 32'(wb_c[wb0+2] - wb_c[wb0]), 2);
    chk("p1_stalls", 32'(stall_n - sn0), 0);
    chk("p1_retired", 32'(c_ret), 3);

    // Store, load, load-use
    mark();
    issue(i_op(OP_SW, 3, 0, 16'd4));
    issue(i_op(OP_LW, 4, 0, 16'd4));
    issue(r_op(5, 4, 4, F_ADD));
    issue(32'h0000_0000);
    idle(8);
    chk("p2_store_count", 32'(st_a.size() - st0), 1);
    chk("p2_store_addr", st_a[st0], 32'd4);
    chk("p2_store_data", st_d[st0], 32'd12);
    chk("p2_stalls", 32'(stall_n - sn0), 1);
    chk("p2_not_ready", 32'(retry_n - rt0), 1);
    chk("p2_wb_count", 32'(wb_a.size() - wb0), 2);
    chk("p2_r4_data", wb_d[wb0], 32'd12);
    chk("p2_r5_addr", 32'(wb_a[wb0+1]), 5);
    chk("p2_r5_data", wb_d[wb0+1], 32'd24);
    chk("p2_retired", 32'(c_ret), 7);

    // Same programs without forwarding
    sel = 1;
    mark();
    issue(i_op(OP_ADDI, 1, 0, 16'd5));
    issue(i_op(OP_ADDI, 2, 0, 16'd7));
    issue(r_op(3, 1, 2, F_ADD));
    idle(8);
    chk("nf1_stalls", 32'(stall_n - sn0), 3);
    chk("nf1_wb_count", 32'(wb_a.size() - wb0), 3);
    chk("nf1_r3_data", wb_d[wb0+2], 32'd12);
    chk("nf1_retired", 32'(c_ret), 3);
    mark();
    issue(i_op(OP_SW, 3, 0, 16'd4));
    issue(i_op(OP_LW, 4, 0, 16'd4));
    issue(r_op(5, 4, 4, F_ADD));
    issue(32'h0000_0000);
    idle(10);
    chk("nf2_stalls", 32'(stall_n - sn0), 3);
    chk("nf2_store_data", st_d[st0], 32'd12);
    chk("nf2_r5_data", wb_d[wb0+1], 32'd24);
    chk("nf2_retired", 32'(c_ret), 7);
    sel = 0;

    // r0 writes suppressed, r0 reads as zero
    mark();
    issue(i_op(OP_ADDI, 0, 0, 16'd9));
    issue(r_op(6, 0, 0, F_ADD));
    idle(6);
    chk("r0_wb_count", 32'(wb_a.size() - wb0), 1);
    chk("r0_r6_addr", 32'(wb_a[wb0]), 6);
    chk("r0_r6_data", wb_d[wb0], 32'd0);
    chk("r0_stalls", 32'(stall_n - sn0), 0);
    chk("r0_retired", 32'(c_ret), 9);

    // Signed compare, subtract, logic ops
    mark();
    issue(i_op(OP_ADDI, 1, 0, 16'hFFFF));
    issue(r_op(2, 1, 0, F_SLT));
    issue(r_op(3, 0, 1, F_SUB));
    issue(r_op(8, 1, 0, F_OR));
    issue(r_op(9, 1, 2, F_AND));
    idle(8);
    chk("alu_wb_count", 32'(wb_a.size() - wb0), 5);
    chk("alu_r1_neg1", wb_d[wb0], 32'hFFFF_FFFF);
    chk("alu_slt", wb_d[wb0+1], 32'd1);
    chk("alu_sub", wb_d[wb0+2], 32'd1);
    chk("alu_or", wb_d[wb0+3], 32'hFFFF_FFFF);
    chk("alu_and", wb_d[wb0+4], 32'd1);
    chk("alu_retired", 32'(c_ret), 14);

    // Flush while the 4th instruction is offered
    mark();
    issue(i_op(OP_ADDI, 10, 0, 16'd1));
    issue(i_op(OP_ADDI, 11, 0, 16'd2));
    issue(i_op(OP_ADDI, 12, 0, 16'd3));
    drv_valid = 1'b1; drv_instr = i_op(OP_ADDI, 13, 0, 16'd4); drv_flush = 1'b1;
    #1 chk("flush_ready", 32'(c_rdy), 0);
    @(posedge d_clk);
    @(negedge d_clk);
    drv_flush = 1'b0;
    idle(6);
    chk("flush_wb_count", 32'(wb_a.size() - wb0), 1);
    chk("flush_survivor_addr", 32'(wb_a[wb0]), 10);
    chk("flush_retired", 32'(c_ret), 15);
    mark();
    issue(r_op(14, 11, 12, F_ADD));
    idle(6);
    chk("flush_r14_data", wb_d[wb0], 32'd0);

    // Reset in mid-stream, then a clean restart
    issue(i_op(OP_ADDI, 1, 0, 16'd3));
    issue(i_op(OP_ADDI, 2, 0, 16'd4));
    issue(i_op(OP_SW, 1, 0, 16'd8));
    issue(i_op(OP_ADDI, 7, 0, 16'd1));
    chk("pre_reset_wb_valid", 32'(wbv_f), 1);
    d_rst = 1'b0;
    #1;
    chk("midrst_wb_valid", 32'(wbv_f), 0);
    chk("midrst_retired", 32'(ret_f), 0);
    chk("midrst_ready", 32'(rdy_f), 0);
    chk("midrst_we", 32'(we_f), 0);
    chk("midrst_re", 32'(re_f), 0);
    repeat (2) @(negedge d_clk);
    d_rst = 1'b1;
    @(negedge d_clk);
    chk("restart_ready", 32'(rdy_f), 1);
    mark();
    issue(i_op(OP_ADDI, 1, 0, 16'd3));
    issue(r_op(2, 1, 1, F_ADD));
    issue(r_op(3, 5, 0, F_ADD));
    idle(6);
    chk("restart_wb_count", 32'(wb_a.size() - wb0), 3);
    chk("restart_r2_data", wb_d[wb0+1], 32'd6);
    chk("restart_r5_cleared", wb_d[wb0+2], 32'd0);
    chk("restart_retired", 32'(c_ret), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
